// File: rtl/input_conditioner.sv
// Purpose : condition raw board inputs for the game FSM (buttons -> sync + debounce + press pulse, switches -> sync only).
// Latency : button press sampled at edge k pulses at edge k+1+DEB_CYCLES; switches appear 2 edges after first sample.
// Backpressure: none; free-running, outputs are registered and never stalled.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset (priority over everything)
//   start_raw          raw start button (async, bouncy)
//   pAb_raw, pBb_raw   raw player A / player B fire buttons (async, bouncy)
//   X_raw, Y_raw       raw 2-bit coordinate switches (async)
//   start, pAb, pBb    one-cycle pulse per accepted press
//   X, Y               synchronized coordinate switches
module input_conditioner #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_raw,
  input  logic       pAb_raw,
  input  logic       pBb_raw,
  input  logic [1:0] X_raw,
  input  logic [1:0] Y_raw,
  output logic       start,
  output logic       pAb,
  output logic       pBb,
  output logic [1:0] X,
  output logic [1:0] Y
);

  localparam int NBTN = 3;  // bit 0 start, bit 1 player A, bit 2 player B

  // Terminal count: the cycle on which the disagreeing level has persisted DEB_CYCLES cycles.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // Button path state
  logic [NBTN-1:0]            btn_raw;
  logic [NBTN-1:0]            btn_s1_q, btn_s1_d;
  logic [NBTN-1:0]            btn_s2_q, btn_s2_d;
  logic [NBTN-1:0]            lvl_q,    lvl_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q,    cnt_d;
  logic [NBTN-1:0]            pulse_q,  pulse_d;

  // Switch path state: {Y, X}, each bit synchronized independently
  logic [3:0] sw_s1_q, sw_s1_d;
  logic [3:0] sw_s2_q, sw_s2_d;

  assign btn_raw = {pBb_raw, pAb_raw, start_raw};

  always_comb begin
    // Two-flop synchronizers
    btn_s1_d = btn_raw;
    btn_s2_d = btn_s1_q;
    sw_s1_d  = {Y_raw, X_raw};
    sw_s2_d  = sw_s1_q;

    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pulse_d = '0;

    for (int i = 0; i < NBTN; i++) begin
      if (btn_s2_q[i] == lvl_q[i]) begin
        // Agreement (or a bounce back) restarts the qualification window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        lvl_d[i] = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // Only an accepted rising level produces a pulse; releases are silent.
      pulse_d[i] = ~lvl_q[i] & lvl_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      lvl_q    <= '0;
      cnt_q    <= '0;
      pulse_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
    end
  end

  assign start = pulse_q[0];
  assign pAb   = pulse_q[1];
  assign pBb   = pulse_q[2];
  assign X     = sw_s2_q[1:0];
  assign Y     = sw_s2_q[3:2];

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end for the game controller. It conditions the raw board inputs (start button, the two player fire buttons, and the X/Y coordinate switches) before they reach the game FSM.
- Buttons pass through a 2-flop synchronizer and a per-button debouncer. Each accepted press produces exactly one single-cycle pulse.
- Switches are 2-flop synchronized only. They are stable well before any pulse is issued.
- Outputs connect one-to-one to the game FSM's start, pAb, pBb, X and Y inputs.

Parameters:
- DEB_CYCLES, 500000, consecutive clk cycles the synchronized button level must differ from the debounced level before it is accepted (10 ms at 50 MHz); must be >= 1.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_raw  in  1  raw start button, active-high, asynchronous/bouncy.
- pAb_raw  in  1  raw player A fire button, active-high.
- pBb_raw  in  1  raw player B fire button, active-high.
- X_raw  in  2  raw X coordinate switches.
- Y_raw  in  2  raw Y coordinate switches.
- start  out  1  one-cycle pulse per accepted start press.
- pAb  out  1  one-cycle pulse per accepted player A press.
- pBb  out  1  one-cycle pulse per accepted player B press.
- X  out  2  synchronized X switches.
- Y  out  2  synchronized Y switches.

Behaviour:
- Reset is synchronous. On any clk edge with rst=1:
  - all sync flops, debounced levels and counters clear to 0;
  - start, pAb, pBb, X and Y all go to 0.
  - rst has priority over all other activity.
- Synchronizer:
  - every raw input (5 button/switch signals, 7 bits total) goes through 2 flops: s1 <= raw, s2 <= s1.
  - X = X_s2 and Y = Y_s2, so a switch change appears on X/Y 2 edges after first being sampled.
  - No debounce on switches; bits are synchronized independently.
- Debouncer, identical and independent per button, with state {lvl, cnt}:
  - if s2 == lvl: cnt <= 0.
  - else if cnt == DEB_CYCLES-1: lvl <= s2 and cnt <= 0.
  - else: cnt <= cnt + 1.
  - Any cycle where s2 returns to lvl restarts the count. A bounce shorter than DEB_CYCLES consecutive cycles is therefore discarded.
- Pulse generation:
  - Registered: pulse <= (lvl flips 0->1 on this edge).
  - Exactly one cycle high per accepted press, regardless of hold duration.
  - A 0->1 flip of lvl is the only trigger; the 1->0 flip (release) produces no pulse.
- Latency: raw button high first sampled at edge k.
  - s2 is high after edge k+1.
  - lvl and pulse go high at edge k+1+DEB_CYCLES.
  - The pulse is high for the cycle following that edge and low after edge k+2+DEB_CYCLES.
- Coordinate coherence: switches must be settled at least 2 cycles before the pulse edge. Because DEB_CYCLES >= 1, X/Y always reflect values sampled with or before the button.
- Simultaneous events:
  - Buttons are fully independent; pAb and pBb may pulse in the same cycle, and both are asserted.
  - Arbitration belongs to the game FSM.
- Re-press: a new pulse requires the debounced level to return to 0 (release accepted for DEB_CYCLES cycles) and then rise again.
- Reset mid-operation:
  - counts and levels are discarded.
  - A button held through rst deassertion is treated as a new press and pulses at edge DEB_CYCLES+2 after the first non-reset edge.
- Counter never exceeds DEB_CYCLES-1; no wrap-around possible.

Test Plan (DEB_CYCLES=4):
- rst=1 for 3 cycles with all raw inputs high -> all outputs 0 during reset. After release, X=3 and Y=3 within 2 cycles; start/pAb/pBb each pulse once, at edge 6 after reset release.
- Clean pAb_raw press held 50 cycles, first sampled at edge k -> pAb high only in the cycle after edge k+5. pBb and start stay 0. No pulse on release.
- pAb_raw bounce pattern 1,1,1,0,1,1,1,0 (per cycle) then steady 1 -> no pulse during bounce. Exactly one pulse 5 edges after the last 0->1 sampled transition.
- pAb_raw and pBb_raw rise on the same edge -> pAb and pBb both pulse in the same cycle, each for exactly 1 cycle.
- X_raw=2 and Y_raw=1 set 1 cycle before the start_raw press -> X=2 and Y=1 when start pulses. X_raw changed to 3 while the button is held -> X=3 two edges later, no extra pulse.
- Press, release held only 3 cycles, then re-press -> single pulse total. Release held ≥4 cycles, then re-press held ≥4 cycles -> second pulse.
